// File: rtl/f16_pkg.sv
// Half-precision (IEEE-754 binary16) field layout and classification helpers.
// Shared by the pooling datapath and any later compare-based stage.
package f16_pkg;

  localparam int unsigned F16_WIDTH    = 16;
  localparam logic [F16_WIDTH-1:0] F16_POS_ZERO = 16'h0000;

  localparam int unsigned F16_SIGN_BIT = 15;
  localparam int unsigned F16_EXP_MSB  = 14;
  localparam int unsigned F16_EXP_LSB  = 10;
  localparam int unsigned F16_MANT_MSB = 9;
  localparam int unsigned F16_MANT_LSB = 0;
  localparam logic [4:0]  F16_EXP_ONES = 5'h1F;

  // Exponent all ones with a non-zero mantissa.
  function automatic logic is_nan(input logic [F16_WIDTH-1:0] v);
    return (v[F16_EXP_MSB:F16_EXP_LSB] == F16_EXP_ONES) &&
           (v[F16_MANT_MSB:F16_MANT_LSB] != '0);
  endfunction

  function automatic logic is_neg(input logic [F16_WIDTH-1:0] v);
    return v[F16_SIGN_BIT];
  endfunction

  // Sign-stripped bits; ordered like the magnitude for all non-NaN values.
  function automatic logic [F16_WIDTH-2:0] mag(input logic [F16_WIDTH-1:0] v);
    return v[F16_EXP_MSB:0];
  endfunction

endpackage

// File: rtl/max_pool_layer_pkg.sv
// Types and elaboration helpers local to the max-pooling stage.
package max_pool_layer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter/index width for a range of n values; never narrower than one bit.
  function automatic int unsigned cw(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/max_pool_layer_if.sv
// Start/map/status bundle between the pooling stage and its neighbours.
//   start   : one-cycle request (master -> slave)
//   in_map  : flat channel-major, row-major input map, element 0 in bits [0:DATA_WIDTH-1]
//   out_map : flat pooled map, same ordering (slave -> master)
//   busy    : scan in progress
//   done    : one-cycle completion pulse
interface max_pool_layer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned D          = 1,
  parameter int unsigned H          = 4,
  parameter int unsigned W          = 4,
  parameter int unsigned P          = 2
);
  localparam int unsigned IN_BITS  = D * H * W * DATA_WIDTH;
  localparam int unsigned OUT_BITS = D * (H / P) * (W / P) * DATA_WIDTH;

  logic                  start;
  logic [0:IN_BITS-1]    in_map;
  logic [0:OUT_BITS-1]   out_map;
  logic                  busy;
  logic                  done;

  modport master (output start, in_map, input  out_map, busy, done);
  modport slave  (input  start, in_map, output out_map, busy, done);
endinterface

// File: rtl/max_pool_layer_f16_max.sv
// Combinational binary16 maximum: a is the running value, b the candidate.
//   a, b  : operands
//   max_c : a unless b is strictly greater; NaN candidates never win, a NaN
//           running value is replaced by any non-NaN candidate, zero ties keep a.
module f16_max
  import f16_pkg::*;
(
  input  logic [F16_WIDTH-1:0] a,
  input  logic [F16_WIDTH-1:0] b,
  output logic [F16_WIDTH-1:0] max_c
);

  always_comb begin
    max_c = a;
    if (is_nan(b)) begin
      max_c = a;
    end else if (is_nan(a)) begin
      max_c = b;
    end else if ((mag(a) == '0) && (mag(b) == '0)) begin
      max_c = a;
    end else if (is_neg(a) != is_neg(b)) begin
      max_c = is_neg(a) ? b : a;
    end else if (!is_neg(a)) begin
      max_c = (mag(b) > mag(a)) ? b : a;
    end else begin
      max_c = (mag(b) < mag(a)) ? b : a;
    end
  end

endmodule

// File: rtl/max_pool_layer.sv
// Float16 PxP max pooling over a latched D x H x W map, one element per cycle.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of max_pool_layer_if (start, in_map, out_map, busy, done)
module max_pool_layer
  import f16_pkg::*;
  import max_pool_layer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned D          = 1,
  parameter int unsigned H          = 4,
  parameter int unsigned W          = 4,
  parameter int unsigned P          = 2,
  parameter bit          RELU       = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  max_pool_layer_if.slave  bus
);

  localparam int unsigned OH    = H / P;
  localparam int unsigned OW    = W / P;
  localparam int unsigned IN_N  = D * H * W;
  localparam int unsigned OUT_N = D * OH * OW;
  localparam int unsigned CH_W  = cw(D);
  localparam int unsigned PR_W  = cw(OH);
  localparam int unsigned PC_W  = cw(OW);
  localparam int unsigned E_W   = cw(P);
  localparam int unsigned IB_W  = cw(IN_N * DATA_WIDTH);
  localparam int unsigned OB_W  = cw(OUT_N * DATA_WIDTH);

  state_e                      state_q, state_d;
  logic [0:IN_N*DATA_WIDTH-1]  map_q;
  logic [0:OUT_N*DATA_WIDTH-1] out_q;
  logic [CH_W-1:0]             ch_q;
  logic [PR_W-1:0]             pr_q;
  logic [PC_W-1:0]             pc_q;
  logic [E_W-1:0]              er_q, ec_q;
  logic [DATA_WIDTH-1:0]       run_max_q;
  logic                        busy_q, done_q;

  logic                        load_c, step_c;
  logic                        ec_last_c, er_last_c, pc_last_c, pr_last_c, ch_last_c;
  logic                        win_last_c, scan_last_c, first_c;
  logic [IB_W-1:0]             in_base_c;
  logic [OB_W-1:0]             out_base_c;
  logic [DATA_WIDTH-1:0]       elem_c, max_c, cand_c, wr_val_c;

  // Window element (er, ec) of output position (ch, pr, pc); trailing rows/cols never addressed.
  assign in_base_c  = IB_W'(((32'(ch_q) * H + 32'(pr_q) * P + 32'(er_q)) * W
                             + 32'(pc_q) * P + 32'(ec_q)) * DATA_WIDTH);
  assign out_base_c = OB_W'(((32'(ch_q) * OH + 32'(pr_q)) * OW + 32'(pc_q)) * DATA_WIDTH);
  assign elem_c     = map_q[in_base_c +: DATA_WIDTH];

  assign ec_last_c   = (ec_q == E_W'(P - 1));
  assign er_last_c   = (er_q == E_W'(P - 1));
  assign pc_last_c   = (pc_q == PC_W'(OW - 1));
  assign pr_last_c   = (pr_q == PR_W'(OH - 1));
  assign ch_last_c   = (ch_q == CH_W'(D - 1));
  assign first_c     = (er_q == '0) && (ec_q == '0);
  assign win_last_c  = ec_last_c && er_last_c;
  assign scan_last_c = win_last_c && pc_last_c && pr_last_c && ch_last_c;

  f16_max u_max (
    .a     (run_max_q),
    .b     (elem_c),
    .max_c (max_c)
  );

  // First element of a window seeds the running max.
  assign cand_c   = first_c ? elem_c : max_c;
  assign wr_val_c = (RELU && cand_c[DATA_WIDTH-1]) ? DATA_WIDTH'(F16_POS_ZERO) : cand_c;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_SCAN;
      ST_SCAN: if (scan_last_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath controls decoded from state.
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    case (state_q)
      ST_IDLE: load_c = bus.start;
      ST_SCAN: step_c = 1'b1;
      default: ;
    endcase
  end

  // Input snapshot so the producer may change in_map after the accepted start.
  always_ff @(posedge clk) begin
    if (load_c) map_q <= bus.in_map;
  end

  // Scan counters, running max, pooled map and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_q      <= '0;
      pr_q      <= '0;
      pc_q      <= '0;
      er_q      <= '0;
      ec_q      <= '0;
      run_max_q <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q <= (state_d == ST_SCAN);
      done_q <= (state_d == ST_DONE);
      if (load_c) begin
        ch_q      <= '0;
        pr_q      <= '0;
        pc_q      <= '0;
        er_q      <= '0;
        ec_q      <= '0;
        run_max_q <= '0;
      end else if (step_c) begin
        run_max_q <= cand_c;
        if (!ec_last_c) begin
          ec_q <= ec_q + E_W'(1);
        end else begin
          ec_q <= '0;
          if (!er_last_c) begin
            er_q <= er_q + E_W'(1);
          end else begin
            er_q <= '0;
            out_q[out_base_c +: DATA_WIDTH] <= wr_val_c;
            if (!pc_last_c) begin
              pc_q <= pc_q + PC_W'(1);
            end else begin
              pc_q <= '0;
              if (!pr_last_c) begin
                pr_q <= pr_q + PR_W'(1);
              end else begin
                pr_q <= '0;
                ch_q <= ch_last_c ? '0 : ch_q + CH_W'(1);
              end
            end
          end
        end
      end
    end
  end

  assign bus.out_map = out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_max_pool_layer.sv
// Directed bench for max_pool_layer over five parameterisations.
module tb_max_pool_layer;

  logic       clk;
  logic       reset;
  logic [4:0] st;
  logic [4:0] dn;
  logic [4:0] bsy;
  int         n_chk;
  int         n_fail;
  logic [15:0] ramp [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: 4x4 P2, 1: 2x2 window, 2: 2x2 window with ReLU, 3: 5x5, 4: two channels 4x4
  max_pool_layer_if #(.DATA_WIDTH(16), .D(1), .H(4), .W(4), .P(2)) if4 ();
  max_pool_layer_if #(.DATA_WIDTH(16), .D(1), .H(2), .W(2), .P(2)) ifw ();
  max_pool_layer_if #(.DATA_WIDTH(16), .D(1), .H(2), .W(2), .P(2)) ifr ();
  max_pool_layer_if #(.DATA_WIDTH(16), .D(1), .H(5), .W(5), .P(2)) if5 ();
  max_pool_layer_if #(.DATA_WIDTH(16), .D(2), .H(4), .W(4), .P(2)) ifd ();

  assign if4.start = st[0];
  assign ifw.start = st[1];
  assign ifr.start = st[2];
  assign if5.start = st[3];
  assign ifd.start = st[4];
  assign dn  = {ifd.done, if5.done, ifr.done, ifw.done, if4.done};
  assign bsy = {ifd.busy, if5.busy, ifr.busy, ifw.busy, if4.busy};

  max_pool_layer #(.DATA_WIDTH(16), .D(1), .H(4), .W(4), .P(2), .RELU(1'b0))
    u_p4 (.clk(clk), .reset(reset), .bus(if4));
  max_pool_layer #(.DATA_WIDTH(16), .D(1), .H(2), .W(2), .P(2), .RELU(1'b0))
    u_pw (.clk(clk), .reset(reset), .bus(ifw));
  max_pool_layer #(.DATA_WIDTH(16), .D(1), .H(2), .W(2), .P(2), .RELU(1'b1))
    u_pr (.clk(clk), .reset(reset), .bus(ifr));
  max_pool_layer #(.DATA_WIDTH(16), .D(1), .H(5), .W(5), .P(2), .RELU(1'b0))
    u_p5 (.clk(clk), .reset(reset), .bus(if5));
  max_pool_layer #(.DATA_WIDTH(16), .D(2), .H(4), .W(4), .P(2), .RELU(1'b0))
    u_pd (.clk(clk), .reset(reset), .bus(ifd));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start on one instance, then watch busy/done for N+4 cycles.
  // Sample n is taken half a cycle after edge t0+n.
  task automatic run(input string tag, input int which, input int n_exp,
                     input bit scramble, input bit restart);
    int busy_n;
    int done_n;
    int done_at;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    @(negedge clk); st[which] = 1'b1;
    @(negedge clk); st[which] = 1'b0;
    if (scramble) if4.in_map = {16{16'h7BFF}};
    for (int n = 0; n < n_exp + 4; n++) begin
      if (bsy[which]) busy_n++;
      if (dn[which]) begin
        done_n++;
        done_at = n;
      end
      st[which] = restart && (n == 2);
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 128'(busy_n), 128'(n_exp));
    check({tag, "_done_pulses"}, 128'(done_n), 128'd1);
    check({tag, "_done_at"}, 128'(done_at), 128'(n_exp));
  endtask

  task automatic load_ramp4();
    for (int i = 0; i < 16; i++) if4.in_map[i*16 +: 16] = ramp[i];
  endtask

  initial begin
    int quiet_done;
    n_chk  = 0;
    n_fail = 0;
    st     = '0;
    reset  = 1'b1;
    ramp = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800,
             16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80, 16'h4C00};
    if4.in_map = '0;
    ifw.in_map = '0;
    ifr.in_map = '0;
    if5.in_map = '0;
    ifd.in_map = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_out_map", 128'(if4.out_map), 128'd0);
    check("rst_out_map_d2", 128'(ifd.out_map), 128'd0);
    check("rst_busy", 128'(bsy), 128'd0);
    check("rst_done", 128'(dn), 128'd0);

    // All-ones map.
    if4.in_map = {16{16'h3C00}};
    run("t1", 0, 16, 1'b0, 1'b0);
    check("t1_out", 128'(if4.out_map), 128'({4{16'h3C00}}));

    // 1.0..16.0 ramp; input changed right after acceptance must not matter.
    load_ramp4();
    run("t2", 0, 16, 1'b1, 1'b0);
    check("t2_out", 128'(if4.out_map), 128'({16'h4600, 16'h4800, 16'h4B00, 16'h4C00}));

    // All-negative window, with and without ReLU.
    ifw.in_map = {16'hC000, 16'hBC00, 16'h8000, 16'hC400};
    ifr.in_map = {16'hC000, 16'hBC00, 16'h8000, 16'hC400};
    run("t3w", 1, 4, 1'b0, 1'b0);
    check("t3_neg_norelu", 128'(ifw.out_map), 128'h8000);
    run("t3r", 2, 4, 1'b0, 1'b0);
    check("t3_neg_relu", 128'(ifr.out_map), 128'h0000);

    // -0 then +0 tie keeps the running -0.
    ifw.in_map = {16'h8000, 16'h0000, 16'hBC00, 16'hC000};
    run("t3t", 1, 4, 1'b0, 1'b0);
    check("t3_zero_tie", 128'(ifw.out_map), 128'h8000);

    // NaN first element replaced by first real value.
    ifw.in_map = {16'h7E00, 16'h3C00, 16'h4000, 16'hBC00};
    run("t4n", 1, 4, 1'b0, 1'b0);
    check("t4_nan_first", 128'(ifw.out_map), 128'h4000);

    // +inf wins, negative NaN candidate ignored, positive passes ReLU.
    ifr.in_map = {16'h3C00, 16'h7C00, 16'h4000, 16'hFE00};
    run("t4i", 2, 4, 1'b0, 1'b0);
    check("t4_inf_relu", 128'(ifr.out_map), 128'h7C00);

    // 5x5: last row and column hold the largest finite value and are never read.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (r == 4 || c == 4) if5.in_map[(r*5+c)*16 +: 16] = 16'h7BFF;
        else                  if5.in_map[(r*5+c)*16 +: 16] = ramp[r*4+c];
      end
    end
    run("t4f", 3, 16, 1'b0, 1'b0);
    check("t4_5x5_out", 128'(if5.out_map), 128'({16'h4600, 16'h4800, 16'h4B00, 16'h4C00}));

    // Two channels.
    ifd.in_map = {{16{16'h3C00}}, {16{16'h4400}}};
    run("t5", 4, 32, 1'b0, 1'b0);
    check("t5_out", 128'(ifd.out_map), {{4{16'h3C00}}, {4{16'h4400}}});

    // Reset mid-scan clears the partial map and suppresses done.
    load_ramp4();
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_rst_out", 128'(if4.out_map), 128'd0);
    check("t6_rst_busy", 128'(bsy[0]), 128'd0);
    quiet_done = 0;
    for (int n = 0; n < 20; n++) begin
      if (dn[0]) quiet_done++;
      @(negedge clk);
    end
    check("t6_no_done", 128'(quiet_done), 128'd0);

    // Second start during the scan is ignored.
    run("t6", 0, 16, 1'b0, 1'b1);
    check("t6_out", 128'(if4.out_map), 128'({16'h4600, 16'h4800, 16'h4B00, 16'h4C00}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/max_pool_layer.md
Name: max_pool_layer

Overview:
- Float16 max-pooling stage directly downstream of the multi-filter convolution layer.
- Consumes the convolution layer's flat output map (K channels of (H-F+1)x(W-F+1) values) after a start pulse.
- Scans each PxP window sequentially, one element per cycle, with optional ReLU; produces a flat pooled map plus a done pulse for the next layer.

Parameters:
- DATA_WIDTH, 16, element width (IEEE-754 half precision).
- D, 1, channel count (equals the conv stage's K).
- H, 4, input map height.
- W, 4, input map width.
- P, 2, pool window size and stride.
- RELU, 0, 1 = clamp negative results to +0 (0x0000).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- in_map  input  [0:D*H*W*DATA_WIDTH-1]  channel-major, row-major; element 0 at bits [0:DATA_WIDTH-1].
- out_map  output  [0:D*(H/P)*(W/P)*DATA_WIDTH-1]  pooled map, same ordering.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when out_map is complete.

Behaviour:
- Reset (async, any state): state=IDLE; out_map, busy, done, counters, running max all 0.
- FSM IDLE -> SCAN -> DONE -> IDLE.
- IDLE: on start=1 at edge t0, latch in_map into an internal register; clear counters; go to SCAN. The latched copy means in_map may change after t0.
- SCAN: counters ch, pr, pc (output position) and e (0..P*P-1 within window). Element index = ch*H*W + (pr*P + e/P)*W + (pc*P + e%P).
  - e=0: running max := element.
  - e>0: running max := f16_max(running max, element).
  - e=P*P-1: write the final max (after ReLU if RELU=1) to out_map slot ch*(H/P)*(W/P) + pr*(W/P) + pc; advance pc, then pr, then ch.
- N = D*(H/P)*(W/P)*P*P. Edges t0+1 .. t0+N process elements; after edge t0+N state=DONE.
- busy=1 from after t0 until after t0+N. done=1 exactly from after t0+N until after t0+N+1. State then returns to IDLE.
- out_map holds its value until the next accepted start. Slots update progressively during SCAN.
- start while in SCAN or DONE is ignored; no queueing.
- Non-multiple dimensions: output size = floor(H/P) x floor(W/P); trailing rows and columns are never read.
- Compare rules (f16_max):
  - Sign differs: the positive operand wins.
  - Both positive: larger magnitude bits win. Both negative: smaller magnitude bits win.
  - Equal or +0/-0 tie: keep the running value.
  - NaN (exp=0x1F, mant!=0) candidate never replaces the running value. A NaN first element is replaced by the first non-NaN candidate.
  - Infinities compare as ordinary magnitudes.
- ReLU: applied at window write; a result with sign=1 (including -0 and negative NaN) becomes 0x0000. Positive values pass unchanged.
- Reset mid-SCAN: partial out_map cleared; no done pulse.

Decomposition:
- Shared package f16_pkg: F16_WIDTH=16, F16_POS_ZERO=16'h0000, sign/exponent/mantissa field positions, exponent-all-ones constant, is_nan/is_neg helper functions.
- One combinational sub-module f16_max (a, b -> max per the rules above), reusable by later pooling and argmax stages.

Test Plan:
1. D=1,H=W=4,P=2, all 0x3C00, start pulse -> out_map = four 0x3C00; busy for 16 cycles; done high exactly at cycle t0+17 (one cycle only).
2. 4x4 map row-major 0x3C00,0x4000,0x4200,...,0x4C00 (1.0..16.0) -> out_map = bottom-right window maxima (6.0,8.0,14.0,16.0 = 0x4600,0x4800,0x4B00,0x4C00).
3. Single window {0xC000,0xBC00,0x8000,0xC400}: RELU=0 -> 0x8000; RELU=1 -> 0x0000. Window {0x8000,0x0000,...neg} -> 0x8000 kept (tie rule).
4. Window {0x7E00,0x3C00,0x4000,0xBC00} -> 0x4000. H=W=5 ramp -> 2x2 output; row 4 and column 4 values (set to 0x7BFF) never appear.
5. D=2 (channel 0 all 0x3C00, channel 1 all 0x4400) -> out_map = four 0x3C00 then four 0x4400; done at t0+33.
6. Assert reset at t0+5 -> out_map=0, busy=0, no done. Then start, with a second start at t0+3 -> ignored; exactly one done pulse at t0+17.
